// File: rtl/uart_pkg.sv
// Shared definitions for the serial link: frame state encoding and default
// frame geometry, reused by the transmitter and the future receiver.
package uart_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t DATA  = 2'd2;
   localparam state_t STOP  = 2'd3;

   localparam int DBIT_DEFAULT    = 8;
   localparam int CLK_DIV_DEFAULT = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Clearable baud divider: bit_end pulses on the last cycle of every CLK_DIV-cycle
// serial bit period, counting from the cycle after clr is released.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_reg;

   // The counter only ever returns to zero through clr or the end-of-bit
   // clear, so it never relies on natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clr || bit_end) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   assign bit_end = !clr && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART 8N1-style transmitter: accepts one word over valid/ready and shifts it
// out LSB first with a start bit and STOP_BITS stop bits on an idle-high line.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT      = DBIT_DEFAULT,
   parameter int CLK_DIV   = CLK_DIV_DEFAULT,
   parameter int STOP_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [DBIT-1:0] in_data,
   output logic            in_ready,
   output logic            tx,
   output logic            busy,
   output logic            tx_done
);

   localparam int BW = $clog2(DBIT + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DBIT - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   state_t          state_reg;
   logic [DBIT-1:0] shift_reg;
   logic [DBIT-1:0] shift_next;
   logic [BW-1:0]   bit_cnt_reg;
   logic            tx_reg;
   logic            tx_done_reg;
   logic            bit_end;

   // Holding the divider in clear while idle restarts the bit period exactly
   // on the accepting edge.
   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_reg == IDLE),
      .bit_end (bit_end)
   );

   assign shift_next = shift_reg >> 1;

   // tx is registered and loaded with the level of the state being entered,
   // so the line changes in the first cycle of each new bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= 1'b1;
         tx_done_reg <= 1'b0;
      end else begin
         tx_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               tx_reg <= 1'b1;
               if (in_valid) begin
                  shift_reg   <= in_data;
                  bit_cnt_reg <= '0;
                  state_reg   <= START;
                  tx_reg      <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state_reg <= DATA;
                  tx_reg    <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt_reg == LAST_DATA) begin
                     state_reg   <= STOP;
                     bit_cnt_reg <= '0;
                     tx_reg      <= 1'b1;
                  end else begin
                     shift_reg   <= shift_next;
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                     tx_reg      <= shift_next[0];
                  end
               end
            end
            default: begin
               tx_reg <= 1'b1;
               if (bit_end) begin
                  if (bit_cnt_reg == LAST_STOP) begin
                     state_reg   <= IDLE;
                     bit_cnt_reg <= '0;
                     tx_done_reg <= 1'b1;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                  end
               end
            end
         endcase
      end
   end

   assign in_ready = (state_reg == IDLE);
   assign busy     = !in_ready;
   assign tx       = tx_reg;
   assign tx_done  = tx_done_reg;

endmodule
